// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Used by muldiv_step and muldiv_sequencer.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply and, when MULDIV_SEQUENCER_DIV_EN
// is defined, one restoring shift-subtract for divide. hi/lo form the 2*WIDTH working pair.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] mul_hi_o,
   output logic [WIDTH-1:0] mul_lo_o
`ifdef MULDIV_SEQUENCER_DIV_EN
   ,
   output logic [WIDTH-1:0] div_hi_o,
   output logic [WIDTH-1:0] div_lo_o
`endif
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] add_sel;

   // Multiplier sits in lo and shifts out LSB-first; the carry of the add lands in hi's MSB.
   always_comb begin
      sum      = {1'b0, hi_i} + {1'b0, opnd_i};
      add_sel  = lo_i[0] ? sum : {1'b0, hi_i};
      mul_hi_o = add_sel[WIDTH:1];
      mul_lo_o = {add_sel[0], lo_i[WIDTH-1:1]};
   end

`ifdef MULDIV_SEQUENCER_DIV_EN
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // The true difference is always below 2^WIDTH when ge holds, so a WIDTH-bit subtract suffices.
   always_comb begin
      shifted  = {hi_i, lo_i[WIDTH-1]};
      ge       = (shifted >= {1'b0, opnd_i});
      diff     = shifted[WIDTH-1:0] - opnd_i;
      div_hi_o = ge ? diff : shifted[WIDTH-1:0];
      div_lo_o = {lo_i[WIDTH-2:0], ge};
   end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide sequencer: WIDTH steps per op, result published in DONE.
// Divider datapath is compiled in only when MULDIV_SEQUENCER_DIV_EN is defined.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero,
   output state_e           dbg_state
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   work_hi_q, work_hi_d;
   logic [WIDTH-1:0]   work_lo_q, work_lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dz_q, dz_d;
   logic               last_step;

   logic [WIDTH-1:0]   mul_hi, mul_lo;
`ifdef MULDIV_SEQUENCER_DIV_EN
   logic [WIDTH-1:0]   div_hi, div_lo;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .hi_i     (work_hi_q),
      .lo_i     (work_lo_q),
      .opnd_i   (opnd_q),
      .mul_hi_o (mul_hi),
      .mul_lo_o (mul_lo)
`ifdef MULDIV_SEQUENCER_DIV_EN
      ,
      .div_hi_o (div_hi),
      .div_lo_o (div_lo)
`endif
   );

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opnd_d    = opnd_q;
      work_hi_d = work_hi_q;
      work_lo_d = work_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dz_d      = dz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               // opnd holds the addend (mul) or divisor (div); work_lo holds multiplier or dividend.
               opnd_d    = (op_div == OP_DIV) ? b : a;
               work_lo_d = (op_div == OP_DIV) ? a : b;
               work_hi_d = '0;
               cnt_d     = '0;
               dz_d      = 1'b0;
               state_d   = (op_div == OP_DIV) ? DIV : MUL;
            end
         end
         MUL: begin
            work_hi_d = mul_hi;
            work_lo_d = mul_lo;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_step) begin
               hi_d    = mul_hi;
               lo_d    = mul_lo;
               state_d = DONE;
            end
         end
         DIV: begin
`ifdef MULDIV_SEQUENCER_DIV_EN
            if (opnd_q == '0) begin
               hi_d    = work_lo_q;
               lo_d    = '1;
               dz_d    = 1'b1;
               state_d = DONE;
            end else begin
               work_hi_d = div_hi;
               work_lo_d = div_lo;
               cnt_d     = cnt_q + CNT_W'(1);
               if (last_step) begin
                  hi_d    = div_hi;
                  lo_d    = div_lo;
                  state_d = DONE;
               end
            end
`else
            dz_d    = 1'b1;
            state_d = DONE;
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         opnd_q    <= '0;
         work_hi_q <= '0;
         work_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opnd_q    <= opnd_d;
         work_hi_q <= work_hi_d;
         work_lo_q <= work_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dz_q      <= dz_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign div_zero  = done & dz_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes expected results, a negedge monitor
// pops and compares on every done pulse and checks hi/lo hold between results.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;

   typedef struct packed {
      logic [31:0]  cyc;
      logic         dz;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         op_div = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;
   state_e       dbg_state;

   int           checks = 0;
   int           failures = 0;
   int unsigned  cyc = 0;
   exp_t         exp_q[$];
   exp_t         mon_e;
   logic [W-1:0] mdl_hi = '0, mdl_lo = '0;
   logic [W-1:0] last_hi = '0, last_lo = '0;

   muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op_div    (op_div),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .div_zero  (div_zero),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      if (reset) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual hi=%0h lo=%0h required no done", hi, lo);
            end else begin
               mon_e = exp_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
               check("result_hi", hi, mon_e.hi);
               check("result_lo", lo, mon_e.lo);
               check("div_zero", div_zero, mon_e.dz);
               mdl_hi = mon_e.hi;
               mdl_lo = mon_e.lo;
            end
         end else begin
            check("hold_hi", hi, mdl_hi);
            check("hold_lo", lo, mdl_lo);
            check("div_zero_quiet", div_zero, 1'b0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Called one step after an edge; start is high for exactly this cycle (cycle 0).
   task automatic issue(input logic op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input int lat, input bit push);
      exp_t e;
      start  = 1'b1;
      op_div = op;
      a      = ia;
      b      = ib;
      if (push) begin
         e.cyc = 32'(cyc + lat);
         e.dz  = edz;
         e.hi  = ehi;
         e.lo  = elo;
         exp_q.push_back(e);
         last_hi = ehi;
         last_lo = elo;
      end
      tick();
      start = 1'b0;
      a     = $urandom();
      b     = $urandom();
   endtask

   task automatic do_div(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] rem, input logic [W-1:0] quo,
                         input logic edz, input int lat);
`ifdef MULDIV_SEQUENCER_DIV_EN
      issue(OP_DIV, ia, ib, rem, quo, edz, lat, 1'b1);
`else
      issue(OP_DIV, ia, ib, last_hi, last_lo, 1'b1, 2, 1'b1);
`endif
   endtask

   // Returns in the first cycle after the done cycle.
   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL wait_done actual=no done required=done within %0d cycles", budget);
      end
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0;
      repeat (3) tick();
      check("rst_state", dbg_state, IDLE);
      check("rst_hi", hi, '0);
      check("rst_lo", lo, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_div_zero", div_zero, 1'b0);
      reset = 1'b1;
      tick();

      // 7*6 with busy window cycles 1..33
      issue(OP_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 1'b1);
      for (int j = 1; j <= 33; j++) begin
         check("busy_inflight", busy, 1'b1);
         tick();
      end
      check("busy_after_done", busy, 1'b0);

      issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b1);
      wait_done(40);

      do_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
      wait_done(40);
      do_div(32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2);
      wait_done(40);

      // Back-to-back: second start lands in the cycle right after done
      issue(OP_MUL, 32'd12345, 32'd678, 32'd0, 32'd8369910, 1'b0, 33, 1'b1);
      wait_done(40);
      issue(OP_MUL, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0, 33, 1'b1);
      wait_done(40);

      // start during busy must be ignored
      issue(OP_MUL, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0, 33, 1'b1);
      repeat (9) tick();
      start  = 1'b1;
      op_div = OP_DIV;
      a      = 32'd3;
      b      = 32'd3;
      tick();
      start  = 1'b0;
      check("ignored_start_state", dbg_state, MUL);
      wait_done(40);

      // Abort by reset at cycle 15: no done, outputs cleared
      issue(OP_MUL, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 33, 1'b0);
      repeat (14) tick();
      reset = 1'b0;
      tick();
      reset   = 1'b1;
      mdl_hi  = '0;
      mdl_lo  = '0;
      last_hi = '0;
      last_lo = '0;
      check("abort_state", dbg_state, IDLE);
      check("abort_hi", hi, '0);
      check("abort_lo", lo, '0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      repeat (40) tick();

      issue(OP_MUL, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 1'b1);
      wait_done(40);

      do_div(32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
      wait_done(40);
      do_div(32'd7, 32'd9, 32'd7, 32'd0, 1'b0, 33);
      wait_done(40);

      issue(OP_MUL, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'hDEAD_BEEF, 1'b0, 33, 1'b1);
      wait_done(40);
      issue(OP_MUL, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 33, 1'b1);
      wait_done(40);

      repeat (5) tick();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL hold the value WIDTH.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
REQ-005 start  input  1  request a new operation; qualified by busy low.
REQ-006 op_div  input  1  0 = unsigned multiply (mul), 1 = unsigned divide (div).
REQ-007 a  input  WIDTH  multiplicand or dividend.
REQ-008 b  input  WIDTH  multiplier or divisor.
REQ-009 busy  output  1  high while an operation is in flight (states MUL, DIV, DONE).
REQ-010 done  output  1  one-cycle pulse; hi/lo are valid and updated in that cycle.
REQ-011 hi  output  WIDTH  upper product, or remainder; read by mfhi.
REQ-012 lo  output  WIDTH  lower product, or quotient.
REQ-013 div_zero  output  1  one-cycle pulse with done when a divide had b == 0.

Function
REQ-014 FSM states: IDLE, MUL, DIV, DONE; state SHALL be IDLE after reset.
REQ-015 IDLE with start=1: latch a and b, clear the counter, go to MUL (op_div=0) or DIV (op_div=1).
REQ-016 start while busy=1: ignore; no latch, no state change.
REQ-017 MUL: one shift-add step per cycle, exactly WIDTH cycles, 2*WIDTH-bit product, unsigned.
REQ-018 DIV: one restoring shift-subtract step per cycle, exactly WIDTH cycles, unsigned.
REQ-019 After the final step, go to DONE; DONE asserts done for one cycle, then returns to IDLE.
REQ-020 Latency, start edge to done cycle: WIDTH+1 cycles; back-to-back start is accepted in the cycle after done.
REQ-021 hi/lo SHALL change only in the done cycle; they hold their values otherwise, including while busy.
REQ-022 mul result: hi = product[2W-1:W], lo = product[W-1:0].
REQ-023 div result: hi = a mod b, lo = a / b.
REQ-024 Divide with b == 0: skip iteration, go directly to DONE (latency 2), hi = a, lo = all ones, div_zero=1.
REQ-025 busy SHALL be combinational from state; busy=0 only in IDLE.

Reset
REQ-026 reset=0 in any state, including mid-operation: state=IDLE, counter=0, hi=0, lo=0, done=0, div_zero=0, busy=0.
REQ-027 An in-flight operation aborted by reset SHALL produce no done pulse.

Configuration
REQ-028 Macro MULDIV_SEQUENCER_DIV_EN defined: divider datapath and DIV state are compiled in, per REQ-018/023/024.
REQ-029 Macro MULDIV_SEQUENCER_DIV_EN undefined: no divider logic; start with op_div=1 goes to DONE (latency 2), hi/lo unchanged, div_zero=1; mul is unaffected.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold the state enum (IDLE/MUL/DIV/DONE), the op_div encoding constants, and the default WIDTH.
REQ-031 One sub-module muldiv_step (combinational, single-iteration add/shift and subtract/shift) SHALL be instantiated; the FSM, counter and registers stay in muldiv_sequencer.

Verification
REQ-032 Reset, then start, op_div=0, a=7, b=6 -> done at cycle 33, hi=0, lo=42, busy high for cycles 1..33.
REQ-033 mul a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-034 div a=100, b=7 -> done at cycle 33, hi=2, lo=14, div_zero=0; div a=5, b=0 -> done at cycle 2, hi=5, lo=32'hFFFFFFFF, div_zero=1.
REQ-035 start pulsed at cycle 10 of an operation with different operands -> ignored; original result is delivered unchanged at cycle 33.
REQ-036 reset=0 at cycle 15 of a mul -> next cycle IDLE, hi=lo=0, no done; new start completes normally.
REQ-037 Build without MULDIV_SEQUENCER_DIV_EN: div a=100, b=7 -> done at cycle 2, div_zero=1, hi/lo retain the previous mul result.
